// File: rtl/encoder_pkg.sv
// Shared types and default widths for the run-length encoder.
package encoder_pkg;

   localparam int DEFAULT_ADDR_WIDTH = 4;
   localparam int DEFAULT_DATA_WIDTH = 8;

   typedef enum logic [2:0] {
      IDLE,
      RD,
      CMP,
      FLUSH,
      DONE
   } state_t;

endpackage

// File: rtl/encoder_sp_ram.sv
// Simple dual-port style RAM: one synchronous write port, one registered read port.
module encoder_sp_ram #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Only the read register is reset; array contents survive reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rdata <= '0;
      end else begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/encoder.sv
// Run-length encoder over on-chip RAMs, started by a level-sensitive cs.
// Optional busy-cycle counter output enabled by defining ENCODER_PERF_EN.
module encoder
   import encoder_pkg::*;
#(
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cs,
   input  logic                  in_we,
   input  logic [ADDR_WIDTH-1:0] in_addr,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_char,
   output logic [DATA_WIDTH-1:0] rd_code,
   output logic [ADDR_WIDTH:0]   run_count,
   output logic                  busy,
   output logic                  done
`ifdef ENCODER_PERF_EN
   ,
   output logic [15:0]           cycles
`endif
);

   state_t                state, next_state;
   logic                  cs_q;
   logic [ADDR_WIDTH-1:0] av;
   logic [ADDR_WIDTH:0]   ao;
   logic [DATA_WIDTH-1:0] ac;
   logic [DATA_WIDTH-1:0] ao_current_char;
   logic [DATA_WIDTH-1:0] a_output_code;
   logic [DATA_WIDTH-1:0] d;
   logic                  in_wr_en;
   logic                  run_end;

   assign busy     = (state == RD) || (state == CMP) || (state == FLUSH);
   assign done     = (state == DONE);
   assign in_wr_en = in_we && ((state == IDLE) || (state == DONE));
   assign run_end  = ((state == CMP) && (ac != '0) && (d != ao_current_char)) || (state == FLUSH);

   encoder_sp_ram #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) input_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (in_wr_en),
      .waddr (in_addr),
      .wdata (in_data),
      .raddr (av),
      .rdata (d)
   );

   encoder_sp_ram #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) output_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (run_end),
      .waddr (ao[ADDR_WIDTH-1:0]),
      .wdata (ao_current_char),
      .raddr (rd_addr),
      .rdata (rd_char)
   );

   encoder_sp_ram #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) output_code_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (run_end),
      .waddr (ao[ADDR_WIDTH-1:0]),
      .wdata (ac),
      .raddr (rd_addr),
      .rdata (rd_code)
   );

   // cs is registered before the FSM sees it, so a start costs one edge of latency.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (cs_q) next_state = RD;
         RD:      next_state = CMP;
         CMP:     next_state = (&av) ? FLUSH : RD;
         FLUSH:   next_state = DONE;
         DONE:    if (!cs_q) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state           <= IDLE;
         cs_q            <= 1'b0;
         av              <= '0;
         ao              <= '0;
         ac              <= '0;
         ao_current_char <= '0;
         a_output_code   <= '0;
         run_count       <= '0;
      end else begin
         state <= next_state;
         cs_q  <= cs;
         case (state)
            IDLE: begin
               if (cs_q) begin
                  av        <= '0;
                  ao        <= '0;
                  ac        <= '0;
                  run_count <= '0;
               end
            end
            CMP: begin
               if (ac == '0) begin
                  ao_current_char <= d;
                  ac              <= DATA_WIDTH'(1);
               end else if (d == ao_current_char) begin
                  ac <= ac + 1'b1;
               end else begin
                  a_output_code   <= ac;
                  ao              <= ao + 1'b1;
                  run_count       <= run_count + 1'b1;
                  ao_current_char <= d;
                  ac              <= DATA_WIDTH'(1);
               end
               if (!(&av)) begin
                  av <= av + 1'b1;
               end
            end
            FLUSH: begin
               a_output_code <= ac;
               ao            <= ao + 1'b1;
               run_count     <= run_count + 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   // Every completed encode writes at least one run, so the last code is never zero.
   always_ff @(posedge clk) begin
      if (rst_n && (state == DONE)) begin
         assert (a_output_code != '0);
      end
   end

`ifdef ENCODER_PERF_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cycles <= '0;
      end else if ((state == IDLE) && (next_state != IDLE)) begin
         cycles <= '0;
      end else if (busy && (cycles != 16'hFFFF)) begin
         cycles <= cycles + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_encoder.sv
// Scoreboard bench for encoder: host reads push expectations, a monitor checks rd_char/rd_code.
module tb_encoder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cs;
   logic       in_we;
   logic [3:0] in_addr;
   logic [7:0] in_data;
   logic [3:0] rd_addr;
   logic [7:0] rd_char;
   logic [7:0] rd_code;
   logic [4:0] run_count;
   logic       busy;
   logic       done;
`ifdef ENCODER_PERF_EN
   logic [15:0] cycles;
`endif

   typedef struct {
      int         idx;
      logic [7:0] ch;
      logic [7:0] code;
   } exp_t;

   exp_t       sb[$];
   exp_t       mon_e;
   logic       rd_req;
   logic       rd_req_q;
   int         cyc;
   int         e0;
   int         errors;
   int         checks;
   logic [7:0] vec [16];
   logic [7:0] exp_char [16];
   logic [7:0] exp_code [16];

   encoder dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cs        (cs),
      .in_we     (in_we),
      .in_addr   (in_addr),
      .in_data   (in_data),
      .rd_addr   (rd_addr),
      .rd_char   (rd_char),
      .rd_code   (rd_code),
      .run_count (run_count),
      .busy      (busy),
      .done      (done)
`ifdef ENCODER_PERF_EN
      ,
      .cycles    (cycles)
`endif
   );

   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) begin
      cyc      <= cyc + 1;
      rd_req_q <= rd_req;
   end

   // Read data is registered in the DUT, so it is valid the cycle after a request.
   always @(negedge clk) begin
      if (rd_req_q) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("[TB] FAIL read_unexpected: rd_char=%h rd_code=%0d with empty scoreboard", rd_char, rd_code);
         end else begin
            mon_e = sb.pop_front();
            if (rd_char !== mon_e.ch || rd_code !== mon_e.code) begin
               errors++;
               $display("[TB] FAIL read[%0d]: got char=%h code=%0d, want char=%h code=%0d",
                        mon_e.idx, rd_char, rd_code, mon_e.ch, mon_e.code);
            end
         end
      end
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
      end
   endtask

   task automatic applyStimulus();
      for (int i = 0; i < 16; i++) begin
         @(posedge clk); #1;
         in_we   = 1'b1;
         in_addr = 4'(i);
         in_data = vec[i];
      end
      @(posedge clk); #1;
      in_we = 1'b0;
   endtask

   task automatic startEncode(input bit hold_cs);
      @(posedge clk); #1;
      cs = 1'b1;
      @(posedge clk); #1;
      e0 = cyc;
      if (!hold_cs) cs = 1'b0;
   endtask

   task automatic waitDone(input string name);
      while (!done && (cyc - e0) < 60) begin
         @(posedge clk); #1;
      end
      checkOutput(name, done ? (cyc - e0) : -1, 34);
   endtask

   task automatic readResults(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         rd_addr = 4'(i);
         rd_req  = 1'b1;
         sb.push_back('{idx: i, ch: exp_char[i], code: exp_code[i]});
      end
      @(posedge clk); #1;
      rd_req = 1'b0;
      @(posedge clk); #1;
      checkOutput("scoreboard_drained", sb.size(), 0);
   endtask

   initial begin
      errors  = 0;
      checks  = 0;
      rst_n   = 1'b0;
      cs      = 1'b0;
      in_we   = 1'b0;
      in_addr = '0;
      in_data = '0;
      rd_addr = '0;
      rd_req  = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_done", done, 0);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_run_count", run_count, 0);
      checkOutput("reset_rd_char", rd_char, 0);
      checkOutput("reset_rd_code", rd_code, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      checkOutput("idle_busy", busy, 0);

      // All-equal input: one run of 16.
      for (int i = 0; i < 16; i++) vec[i] = 8'h41;
      applyStimulus();
      startEncode(1'b0);
      checkOutput("equal_busy_started", busy, 0);
      @(posedge clk); #1;
      checkOutput("equal_busy_running", busy, 1);
      waitDone("equal_latency");
      checkOutput("equal_run_count", run_count, 1);
`ifdef ENCODER_PERF_EN
      checkOutput("equal_cycles", cycles, 33);
`endif
      exp_char[0] = 8'h41;
      exp_code[0] = 8'd16;
      readResults(1);
      checkOutput("equal_back_to_idle", done, 0);

      // All-distinct input: sixteen runs of length one.
      for (int i = 0; i < 16; i++) begin
         vec[i]      = 8'(i);
         exp_char[i] = 8'(i);
         exp_code[i] = 8'd1;
      end
      applyStimulus();
      startEncode(1'b0);
      waitDone("distinct_latency");
      checkOutput("distinct_run_count", run_count, 16);
      readResults(16);

      // Mixed runs 3xAA, 5x55, 8x0F.
      for (int i = 0; i < 16; i++) vec[i] = (i < 3) ? 8'hAA : (i < 8) ? 8'h55 : 8'h0F;
      exp_char[0] = 8'hAA; exp_code[0] = 8'd3;
      exp_char[1] = 8'h55; exp_code[1] = 8'd5;
      exp_char[2] = 8'h0F; exp_code[2] = 8'd8;
      applyStimulus();
      startEncode(1'b0);
      waitDone("mixed_latency");
      checkOutput("mixed_run_count", run_count, 3);
      readResults(3);

      // Reset mid-run aborts to IDLE and clears run_count; a fresh start still works.
      startEncode(1'b0);
      repeat (9) begin
         @(posedge clk); #1;
      end
      checkOutput("midreset_busy_before", busy, 1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      checkOutput("midreset_busy", busy, 0);
      checkOutput("midreset_done", done, 0);
      checkOutput("midreset_run_count", run_count, 0);
      rst_n = 1'b1;
      startEncode(1'b0);
      waitDone("restart_latency");
      checkOutput("restart_run_count", run_count, 3);
      readResults(3);

      // Host writes while busy are dropped; cs held high keeps DONE without restarting.
      for (int i = 0; i < 16; i++) vec[i] = 8'h41;
      applyStimulus();
      startEncode(1'b1);
      repeat (3) begin
         @(posedge clk); #1;
      end
      in_we   = 1'b1;
      in_addr = 4'd15;
      in_data = 8'h99;
      @(posedge clk); #1;
      in_addr = 4'd3;
      @(posedge clk); #1;
      in_we = 1'b0;
      waitDone("blocked_latency");
      checkOutput("blocked_run_count", run_count, 1);
      repeat (4) begin
         @(posedge clk); #1;
      end
      checkOutput("hold_done", done, 1);
      checkOutput("hold_busy", busy, 0);
      cs = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
      end
      checkOutput("release_done", done, 0);
      checkOutput("release_busy", busy, 0);
      startEncode(1'b0);
      waitDone("reencode_latency");
      checkOutput("reencode_run_count", run_count, 1);
      exp_char[0] = 8'h41;
      exp_code[0] = 8'd16;
      readResults(1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/encoder.md
Name: encoder

Overview:
- Run-length encoder over on-chip memories.
- Scans a 2^ADDR_WIDTH-entry input RAM of DATA_WIDTH-bit characters.
- Writes each run's character to an output RAM and its run length to an output-code RAM, compacted from address 0.
- Started by chip-select. Sits behind a host that loads input and reads results through simple memory ports.

Parameters:
- ADDR_WIDTH, 4, address width; all three RAMs hold DEPTH = 2^ADDR_WIDTH entries; every input entry is encoded.
- DATA_WIDTH, 8, character width and run-length width. Requires 2^ADDR_WIDTH <= 2^DATA_WIDTH-1.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- cs  in  1  start/enable; level-sensitive
- in_we  in  1  host write strobe to input RAM
- in_addr  in  ADDR_WIDTH  host write address
- in_data  in  DATA_WIDTH  host write data
- rd_addr  in  ADDR_WIDTH  host read address for output RAMs
- rd_char  out  DATA_WIDTH  output_ram[rd_addr], registered, 1-cycle latency
- rd_code  out  DATA_WIDTH  output_code_ram[rd_addr], registered, 1-cycle latency
- run_count  out  ADDR_WIDTH+1  number of valid runs written
- busy  out  1  high in any state except IDLE and DONE
- done  out  1  high in DONE

Behaviour:
- One clock. Reset is synchronous and active-low on rst_n.
- Reset: state=IDLE; av, ao, ac, ao_current_char, a_output_code, run_count=0; busy=0; done=0; rd_char, rd_code=0. RAM contents are not cleared.
- Internal registers:
  - av: input read address.
  - ao: output write address.
  - ac: current run length.
  - ao_current_char: current run character.
  - a_output_code: last code written.
- Memories: three instances input_ram, output_ram, output_code_ram. Each has array mem, synchronous write, synchronous read with 1-cycle latency.
- Host load: in_we is honoured only in IDLE or DONE; ignored while busy.
- States: IDLE, RD, CMP, FLUSH, DONE.
- IDLE: if cs=1 at an edge, go to RD with av=0, ao=0, ac=0, run_count=0.
- RD: drive input_ram read at av; go to CMP.
- CMP: compare read data d against the current run.
  - ac==0 (first element): ao_current_char=d, ac=1.
  - d==ao_current_char: ac=ac+1.
  - Otherwise: write output_ram[ao]=ao_current_char and output_code_ram[ao]=ac; a_output_code=ac; ao++; run_count++; then ao_current_char=d, ac=1.
  - If av==DEPTH-1, go to FLUSH; else av++ and go to RD.
- FLUSH: write final run at ao (same write as CMP mismatch); ao++, run_count++; go to DONE.
- DONE: done=1 and outputs hold. cs=0 returns to IDLE with done=0; cs=1 stays in DONE (no auto-restart).
- Latency: with cs sampled high at edge E0, done is high after edge E0+34 (16 RD/CMP pairs, then FLUSH, then DONE entry).
- cs dropping mid-run: ignored; the encode completes.
- rst_n low mid-run: aborts to IDLE next edge; partial output RAM contents remain; run_count=0.
- Wrap: av stops at DEPTH-1; ao never exceeds DEPTH (maximum runs = DEPTH).
- Host reads of output RAMs are valid in any state.

Optional Feature:
- Macro ENCODER_PERF_EN.
- Defined: adds output cycles[15:0].
  - Cleared on leaving IDLE.
  - Increments every cycle while busy; saturates at 0xFFFF.
  - Holds in DONE. Reset to 0.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Package encoder_pkg: state enum type (IDLE, RD, CMP, FLUSH, DONE) and default width constants.
- Sub-module encoder_sp_ram (parameterized ADDR_WIDTH/DATA_WIDTH, one write port, one registered read port, array named mem), instantiated three times.

Test Plan:
- Reset then idle: rst_n low 1 cycle -> done=0, busy=0, run_count=0, state IDLE.
- All-equal input: load 16×0x41, pulse cs -> done at E0+34, run_count=1, output_ram[0]=0x41, output_code_ram[0]=16.
- All-distinct input: load 0x00..0x0F -> run_count=16, output_ram[i]=i, output_code_ram[i]=1 for all i.
- Mixed runs: input 3×0xAA, 5×0x55, 8×0x0F -> run_count=3, chars {AA,55,0F}, codes {3,5,8}.
- Reset mid-run: assert rst_n low at E0+10 -> IDLE next edge, run_count=0; a fresh cs start then produces correct results.
- Load blocked while busy: in_we during RD/CMP -> input_ram unchanged; cs held high after DONE -> no restart; cs low -> IDLE.
